// File: rtl/arb2_mux64_ctrl_if.sv
// arb2_mux64_ctrl_if: request, mux and output-handshake bundle
// for the two-requester 64-bit mux sequencer.
interface arb2_mux64_ctrl_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             req0;
  logic             req1;
  logic             ack0;
  logic             ack1;
  logic             sel;
  logic [WIDTH-1:0] mux_o;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    input  req0, req1, mux_o, o_ready,
    output ack0, ack1, sel, o_valid, o_data, cnt0, cnt1
  );

  modport slave (
    output req0, req1, mux_o, o_ready,
    input  ack0, ack1, sel, o_valid, o_data, cnt0, cnt1
  );
endinterface

// File: rtl/arb2_mux64_ctrl.sv
// arb2_mux64_ctrl: arbitrates two requesters onto a 2:1 mux,
// registers the mux output and offers it with valid/ready.
module arb2_mux64_ctrl #(
  parameter int WIDTH      = 64,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  arb2_mux64_ctrl_if.master      bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam bit P_FIXED = (FIXED_PRIO != 0);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_valid;
  logic w_slot_free;
  logic w_both;
  logic w_grant;
  logic w_win;

  assign w_valid     = (r_state == FULL);
  assign w_slot_free = !w_valid | bus.o_ready;
  assign w_both      = bus.req0 & bus.req1;
  assign w_grant     = w_slot_free & (bus.req0 | bus.req1) & !rst;

  // Winner: sole requester, else fixed 0 or alternate from last.
  always_comb begin
    w_win = bus.req1;
    if (w_both) w_win = P_FIXED ? 1'b0 : !r_last;
  end

  assign bus.ack0    = w_grant & !w_win;
  assign bus.ack1    = w_grant & w_win;
  assign bus.sel     = rst ? 1'b1 : (w_grant ? w_win : r_last);
  assign bus.o_valid = w_valid;
  assign bus.o_data  = r_data;
  assign bus.cnt0    = r_cnt0;
  assign bus.cnt1    = r_cnt1;

  // Capture on grant, drain on accept, count per-requester words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_last  <= 1'b1;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else if (w_grant) begin
      r_state <= FULL;
      r_data  <= bus.mux_o;
      r_last  <= w_win;
      if (w_win) r_cnt1 <= r_cnt1 + 1'b1;
      else       r_cnt0 <= r_cnt0 + 1'b1;
    end else if (w_valid & bus.o_ready) begin
      r_state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_arb2_mux64_ctrl.sv
// tb_arb2_mux64_ctrl: directed and random stimulus on three
// configurations (round-robin, fixed priority, 4-bit counters).
module tb_arb2_mux64_ctrl;

  logic        clk = 1'b0;
  logic        t_rst = 1'b1;
  logic        t_req0 = 1'b0;
  logic        t_req1 = 1'b0;
  logic        t_rdy = 1'b0;
  logic [63:0] t_data = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  arb2_mux64_ctrl_if #(.WIDTH(64), .CNT_W(16)) if_rr ();
  arb2_mux64_ctrl_if #(.WIDTH(64), .CNT_W(16)) if_fp ();
  arb2_mux64_ctrl_if #(.WIDTH(64), .CNT_W(4))  if_w  ();

  assign if_rr.req0 = t_req0;
  assign if_rr.req1 = t_req1;
  assign if_rr.mux_o = t_data;
  assign if_rr.o_ready = t_rdy;
  assign if_fp.req0 = t_req0;
  assign if_fp.req1 = t_req1;
  assign if_fp.mux_o = t_data;
  assign if_fp.o_ready = t_rdy;
  assign if_w.req0 = t_req0;
  assign if_w.req1 = t_req1;
  assign if_w.mux_o = t_data;
  assign if_w.o_ready = t_rdy;

  arb2_mux64_ctrl #(.WIDTH(64), .FIXED_PRIO(0), .CNT_W(16)) u_rr (
    .clk(clk), .rst(t_rst), .bus(if_rr.master)
  );
  arb2_mux64_ctrl #(.WIDTH(64), .FIXED_PRIO(1), .CNT_W(16)) u_fp (
    .clk(clk), .rst(t_rst), .bus(if_fp.master)
  );
  arb2_mux64_ctrl #(.WIDTH(64), .FIXED_PRIO(0), .CNT_W(4)) u_w (
    .clk(clk), .rst(t_rst), .bus(if_w.master)
  );

  logic        g_ack0 [3];
  logic        g_ack1 [3];
  logic        g_sel  [3];
  logic        g_vld  [3];
  logic [63:0] g_data [3];
  logic [15:0] g_cnt0 [3];
  logic [15:0] g_cnt1 [3];

  assign g_ack0[0] = if_rr.ack0;
  assign g_ack0[1] = if_fp.ack0;
  assign g_ack0[2] = if_w.ack0;
  assign g_ack1[0] = if_rr.ack1;
  assign g_ack1[1] = if_fp.ack1;
  assign g_ack1[2] = if_w.ack1;
  assign g_sel[0]  = if_rr.sel;
  assign g_sel[1]  = if_fp.sel;
  assign g_sel[2]  = if_w.sel;
  assign g_vld[0]  = if_rr.o_valid;
  assign g_vld[1]  = if_fp.o_valid;
  assign g_vld[2]  = if_w.o_valid;
  assign g_data[0] = if_rr.o_data;
  assign g_data[1] = if_fp.o_data;
  assign g_data[2] = if_w.o_data;
  assign g_cnt0[0] = if_rr.cnt0;
  assign g_cnt0[1] = if_fp.cnt0;
  assign g_cnt0[2] = {12'd0, if_w.cnt0};
  assign g_cnt1[0] = if_rr.cnt1;
  assign g_cnt1[1] = if_fp.cnt1;
  assign g_cnt1[2] = {12'd0, if_w.cnt1};

  // reference model state, one slot per configuration
  bit          m_prio [3] = '{0, 1, 0};
  int          m_mod  [3] = '{65536, 65536, 16};
  bit          m_known = 0;
  bit          m_vld  [3];
  logic [63:0] m_data [3];
  bit          m_last [3];
  int          m_cnt  [3][2];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit r0, input bit r1,
                     input bit rdy, input logic [63:0] d);
    bit grant;
    bit w;
    bit esel;
    @(negedge clk);
    t_rst = rst;
    t_req0 = r0;
    t_req1 = r1;
    t_rdy = rdy;
    t_data = d;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (m_known) begin
        check($sformatf("valid[%0d]", k), 64'(g_vld[k]), 64'(m_vld[k]));
        check($sformatf("data[%0d]", k), g_data[k], m_data[k]);
        check($sformatf("cnt0[%0d]", k), 64'(g_cnt0[k]),
              64'(m_cnt[k][0]));
        check($sformatf("cnt1[%0d]", k), 64'(g_cnt1[k]),
              64'(m_cnt[k][1]));
      end
      grant = !rst && (r0 || r1) && (!m_known || !m_vld[k] || rdy);
      if (r0 && r1) w = m_prio[k] ? 1'b0 : !m_last[k];
      else          w = r1;
      if (rst)        esel = 1'b1;
      else if (grant) esel = w;
      else            esel = m_last[k];
      check($sformatf("ack0[%0d]", k), 64'(g_ack0[k]),
            64'(grant && !w));
      check($sformatf("ack1[%0d]", k), 64'(g_ack1[k]),
            64'(grant && w));
      if (rst || m_known)
        check($sformatf("sel[%0d]", k), 64'(g_sel[k]), 64'(esel));
      if (rst) begin
        m_vld[k] = 0;
        m_data[k] = '0;
        m_last[k] = 1;
        m_cnt[k][0] = 0;
        m_cnt[k][1] = 0;
      end else if (grant) begin
        m_vld[k] = 1;
        m_data[k] = d;
        m_last[k] = w;
        m_cnt[k][w] = (m_cnt[k][w] + 1) % m_mod[k];
      end else if (m_vld[k] && rdy) begin
        m_vld[k] = 0;
      end
    end
    if (rst) m_known = 1;
    @(posedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_vld[k] = 0;
      m_data[k] = '0;
      m_last[k] = 1;
      m_cnt[k][0] = 0;
      m_cnt[k][1] = 0;
    end
    // reset with both requesting and ready high
    cyc(1, 1, 1, 1, 64'h1111);
    cyc(1, 1, 1, 1, 64'h2222);
    // single request from requester 0
    cyc(0, 1, 0, 1, 64'hDEAD_BEEF_0000_0001);
    cyc(0, 0, 0, 1, 64'h0);
    // both requesting for 4 cycles
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 1, 1, {$urandom, $urandom});
    // backpressure while full
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 1, 0, {$urandom, $urandom});
    cyc(0, 0, 1, 1, 64'hCAFE_F00D_1234_5678);
    cyc(0, 0, 0, 1, 64'h0);
    cyc(0, 0, 0, 0, 64'h0);
    // both requesting for 5 cycles
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 1, 1, {$urandom, $urandom});
    // 16 words from requester 1 wraps the 4-bit counter
    for (int i = 0; i < 16; i++)
      cyc(0, 0, 1, 1, {$urandom, $urandom});
    cyc(0, 0, 0, 1, 64'h0);
    // mid-transfer reset discards held word
    cyc(0, 1, 0, 0, 64'h5555);
    cyc(1, 1, 1, 0, 64'h6666);
    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
          $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
          {$urandom, $urandom});
    cyc(0, 0, 0, 1, 64'h0);
    cyc(0, 0, 0, 1, 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arb2_mux64_ctrl.md
# arb2_mux64_ctrl

Two-requester arbiter and sequencer for the shared 64-bit 2:1 datapath mux. It picks one of two requesters each cycle and drives the mux select. It captures the mux output into an output register and offers it downstream with a valid/ready handshake. Per-requester transfer counters support debug and microcode statistics.

## Interface
- WIDTH, 64, data width of the mux output and the output register
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties
- CNT_W, 16, width of each transfer counter
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- req0  in  1  requester 0 has a word on mux input I0
- req1  in  1  requester 1 has a word on mux input I1
- ack0  out  1  combinational; requester 0's word is taken this cycle
- ack1  out  1  combinational; requester 1's word is taken this cycle
- sel  out  1  drives the mux select s (0 = I0, 1 = I1)
- mux_o  in  WIDTH  mux output o
- o_valid  out  1  o_data holds an unconsumed word
- o_ready  in  1  downstream accepts o_data this cycle
- o_data  out  WIDTH  captured word
- cnt0  out  CNT_W  number of words accepted from requester 0 (wraps)
- cnt1  out  CNT_W  number of words accepted from requester 1 (wraps)

## Operation
- Two states, derived from o_valid:
  - EMPTY (o_valid=0)
  - FULL (o_valid=1)
- slot_free = !o_valid | o_ready.
- Grant exists when slot_free & (req0 | req1) & !rst.
- Winner w:
  - Only one request: that requester wins.
  - Both request, FIXED_PRIO=1: w=0.
  - Both request, FIXED_PRIO=0: w = !last, where last is the previous winner.
- ack_w=1 only when a grant exists and w is the winner; the other ack is 0.
- A transfer is req_w & ack_w in the same cycle. The requester may change its data or req on the next cycle.
- sel = w when a grant exists, otherwise sel = last. The mux select only moves on a grant.
- On the edge after a grant:
  - o_data <= mux_o
  - o_valid <= 1
  - last <= w
  - cnt_w <= cnt_w + 1, modulo 2^CNT_W
- On the edge where o_valid & o_ready with no grant: o_valid <= 0. o_data holds its value.
- Simultaneous accept and grant: o_valid stays 1 and o_data is replaced. This gives back-to-back throughput of 1 word/cycle.
- FULL with o_ready=0: no acks, and o_data, sel and counters are stable. Requests wait; nothing is dropped.
- Reset, including mid-transfer:
  - o_valid=0, o_data=0, last=1 (so requester 0 wins the first tie), cnt0=cnt1=0.
  - ack0=ack1=0 and sel=1 (follows last) while rst=1.
  - A held but unconsumed word is discarded.

## Timing
- ack0, ack1 and sel are combinational from req0, req1, o_valid, o_ready, last and rst. There are no registered outputs on the request side.
- Latency: grant cycle N gives o_valid=1 with the captured data in cycle N+1.
- Counters update in the same edge as the capture, so they are visible in N+1.
- Sustained throughput is 1 word/cycle while o_ready=1 and requests are present.
- Fairness under FIXED_PRIO=0: with both requesting continuously, grants strictly alternate. Neither requester waits more than one grant.

## Test plan
- Reset: hold rst=1 for 2 cycles with req0=req1=1 and o_ready=1 -> ack0=ack1=0, sel=1, o_valid=0, o_data=0, cnt0=cnt1=0.
- Single request: after reset, req0=1, mux_o=64'hDEAD_BEEF_0000_0001, o_ready=1 -> ack0=1 and sel=0 in the same cycle. Next cycle: o_valid=1, o_data=64'hDEAD_BEEF_0000_0001, cnt0=1.
- Round-robin: req0=req1=1 for 4 cycles, o_ready=1, FIXED_PRIO=0 -> grants and sel go 0,1,0,1. o_valid stays 1 from cycle 2. cnt0=2 and cnt1=2 at the end.
- Backpressure: FULL with o_ready=0 and req1=1 for 3 cycles -> ack1=0 and o_data unchanged. Raise o_ready -> ack1=1 and sel=1 that cycle, new o_data next cycle, cnt1 +1.
- Fixed priority: FIXED_PRIO=1, req0=req1=1 for 5 cycles with o_ready=1 -> ack0=1 every cycle, ack1 never asserts, cnt0=5, cnt1=0.
- Counter wrap: CNT_W=4, 16 accepted words from requester 1 -> cnt1 returns to 0 and cnt0 is unaffected.
